// File: rtl/brick_field_if.sv
// Frame/pixel/ball inputs and hit, score and pixel-lookup outputs of the brick field.
// The master side drives the frame and ball; the slave side is the brick field itself.
interface brick_field_if #(
  parameter int unsigned HP_W    = 2,
  parameter int unsigned SCORE_W = 12
);
  logic               frame_tick;
  logic [10:0]        pix_x;
  logic [10:0]        pix_y;
  logic [10:0]        ball_x_l;
  logic [10:0]        ball_x_r;
  logic [10:0]        ball_y_t;
  logic [10:0]        ball_y_b;
  logic               brick_on;
  logic [HP_W-1:0]    brick_hp;
  logic               hit_valid;
  logic               bounce_x;
  logic               bounce_y;
  logic [3:0]         hit_row;
  logic [3:0]         hit_col;
  logic [SCORE_W-1:0] score;
  logic [7:0]         bricks_left;
  logic               field_clear;

  modport master (
    output frame_tick, pix_x, pix_y, ball_x_l, ball_x_r, ball_y_t, ball_y_b,
    input  brick_on, brick_hp, hit_valid, bounce_x, bounce_y, hit_row, hit_col,
    input  score, bricks_left, field_clear
  );

  modport slave (
    input  frame_tick, pix_x, pix_y, ball_x_l, ball_x_r, ball_y_t, ball_y_b,
    output brick_on, brick_hp, hit_valid, bounce_x, bounce_y, hit_row, hit_col,
    output score, bricks_left, field_clear
  );
endinterface

// File: rtl/brick_field.sv
// Breakout brick field: per-brick hit points, pixel lookup for video, and a per-frame
// ball collision scan that hits at most one brick and requests a bounce axis.
module brick_field #(
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned NUM_COLS = 5,
  parameter int unsigned X0       = 9,
  parameter int unsigned Y0       = 4,
  parameter int unsigned BRICK_W  = 106,
  parameter int unsigned BRICK_H  = 16,
  parameter int unsigned GAP_X    = 8,
  parameter int unsigned GAP_Y    = 7,
  parameter int unsigned HP_W     = 2,
  parameter int unsigned INIT_HP  = 1,
  parameter int unsigned SCORE_W  = 12,
  parameter int unsigned PTS_HIT  = 1,
  parameter int unsigned PTS_KILL = 4
) (
  input logic          clk,
  input logic          reset,
  brick_field_if.slave bus
);
  localparam int unsigned NUM_BRICKS = NUM_ROWS * NUM_COLS;
  localparam int unsigned IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
  localparam int unsigned STEP_X     = BRICK_W + GAP_X;
  localparam int unsigned STEP_Y     = BRICK_H + GAP_Y;
  localparam int unsigned SCORE_MAX  = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {StIdle, StScan, StResolve, StUpdate} state_e;

  state_e state_q, state_d;
  logic start, scan_en, resolve_en, update_en;

  logic [HP_W-1:0]    hp_q [NUM_BRICKS];
  logic [10:0]        bx_l_q, bx_r_q, by_t_q, by_b_q;
  logic [3:0]         scan_r_q, scan_c_q;
  logic [IDX_W-1:0]   scan_idx_q;
  logic               cap_valid_q;
  logic [3:0]         cap_r_q, cap_c_q;
  logic [IDX_W-1:0]   cap_idx_q;
  logic               sel_x_q;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]         bricks_left_q;
  logic               hit_valid_q, bounce_x_q, bounce_y_q;
  logic [3:0]         hit_row_q, hit_col_q;
  logic               brick_on_q;
  logic [HP_W-1:0]    brick_hp_q;

  function automatic logic [11:0] col_left(logic [3:0] c);
    return 12'(X0 + STEP_X * 32'(c));
  endfunction

  function automatic logic [11:0] row_top(logic [3:0] r);
    return 12'(Y0 + STEP_Y * 32'(r));
  endfunction

  // Scan-time overlap against the latched ball.
  logic [11:0] s_left, s_right, s_top, s_bottom;
  logic        scan_last, overlap;
  always_comb begin
    s_left    = col_left(scan_c_q);
    s_right   = s_left + 12'(BRICK_W - 1);
    s_top     = row_top(scan_r_q);
    s_bottom  = s_top + 12'(BRICK_H - 1);
    scan_last = (scan_idx_q == IDX_W'(NUM_BRICKS - 1));
    overlap   = (hp_q[scan_idx_q] != '0) &&
                ({1'b0, bx_r_q} >= s_left) && ({1'b0, bx_l_q} <= s_right) &&
                ({1'b0, by_b_q} >= s_top)  && ({1'b0, by_t_q} <= s_bottom);
  end

  // Penetration depth per axis decides which velocity component to reflect.
  logic [11:0] c_left, c_right, c_top, c_bottom, ox_a, ox_b, oy_a, oy_b, ox, oy;
  always_comb begin
    c_left   = col_left(cap_c_q);
    c_right  = c_left + 12'(BRICK_W - 1);
    c_top    = row_top(cap_r_q);
    c_bottom = c_top + 12'(BRICK_H - 1);
    ox_a     = {1'b0, bx_r_q} - c_left + 12'd1;
    ox_b     = c_right - {1'b0, bx_l_q} + 12'd1;
    oy_a     = {1'b0, by_b_q} - c_top + 12'd1;
    oy_b     = c_bottom - {1'b0, by_t_q} + 12'd1;
    ox       = (ox_a < ox_b) ? ox_a : ox_b;
    oy       = (oy_a < oy_b) ? oy_a : oy_b;
  end

  logic [HP_W-1:0]    cap_hp;
  logic               kill;
  int unsigned        score_sum;
  logic [SCORE_W-1:0] score_next;
  always_comb begin
    cap_hp     = hp_q[cap_idx_q];
    kill       = (cap_hp == HP_W'(1));
    score_sum  = 32'(score_q) + PTS_HIT + (kill ? PTS_KILL : 0);
    score_next = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
  end

  // Pixel to brick lookup: rows and columns resolved independently.
  int unsigned      pix_row, pix_col;
  logic             pix_row_hit, pix_col_hit;
  logic [IDX_W-1:0] pix_idx;
  always_comb begin
    pix_row     = 0;
    pix_col     = 0;
    pix_row_hit = 1'b0;
    pix_col_hit = 1'b0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (32'(bus.pix_y) >= Y0 + r * STEP_Y && 32'(bus.pix_y) < Y0 + r * STEP_Y + BRICK_H) begin
        pix_row     = r;
        pix_row_hit = 1'b1;
      end
    end
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (32'(bus.pix_x) >= X0 + c * STEP_X && 32'(bus.pix_x) < X0 + c * STEP_X + BRICK_W) begin
        pix_col     = c;
        pix_col_hit = 1'b1;
      end
    end
    pix_idx = IDX_W'(pix_row * NUM_COLS + pix_col);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.frame_tick && !bus.field_clear) state_d = StScan;
      StScan:    if (scan_last) state_d = StResolve;
      StResolve: state_d = cap_valid_q ? StUpdate : StIdle;
      StUpdate:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    start      = (state_q == StIdle) && bus.frame_tick && !bus.field_clear;
    scan_en    = (state_q == StScan);
    resolve_en = (state_q == StResolve);
    update_en  = (state_q == StUpdate);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bx_l_q      <= '0;
      bx_r_q      <= '0;
      by_t_q      <= '0;
      by_b_q      <= '0;
      scan_r_q    <= '0;
      scan_c_q    <= '0;
      scan_idx_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_r_q     <= '0;
      cap_c_q     <= '0;
      cap_idx_q   <= '0;
      sel_x_q     <= 1'b0;
    end else if (start) begin
      bx_l_q      <= bus.ball_x_l;
      bx_r_q      <= bus.ball_x_r;
      by_t_q      <= bus.ball_y_t;
      by_b_q      <= bus.ball_y_b;
      scan_r_q    <= '0;
      scan_c_q    <= '0;
      scan_idx_q  <= '0;
      cap_valid_q <= 1'b0;
    end else if (scan_en) begin
      if (overlap && !cap_valid_q) begin
        cap_valid_q <= 1'b1;
        cap_r_q     <= scan_r_q;
        cap_c_q     <= scan_c_q;
        cap_idx_q   <= scan_idx_q;
      end
      if (scan_last) begin
        scan_r_q   <= '0;
        scan_c_q   <= '0;
        scan_idx_q <= '0;
      end else begin
        scan_idx_q <= scan_idx_q + IDX_W'(1);
        if (scan_c_q == 4'(NUM_COLS - 1)) begin
          scan_c_q <= '0;
          scan_r_q <= scan_r_q + 4'd1;
        end else begin
          scan_c_q <= scan_c_q + 4'd1;
        end
      end
    end else if (resolve_en) begin
      sel_x_q <= (ox < oy);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BRICKS; i++) hp_q[i] <= HP_W'(INIT_HP);
      score_q       <= '0;
      bricks_left_q <= 8'(NUM_BRICKS);
      hit_valid_q   <= 1'b0;
      bounce_x_q    <= 1'b0;
      bounce_y_q    <= 1'b0;
      hit_row_q     <= '0;
      hit_col_q     <= '0;
      brick_on_q    <= 1'b0;
      brick_hp_q    <= '0;
    end else begin
      hit_valid_q <= update_en;
      bounce_x_q  <= update_en && sel_x_q;
      bounce_y_q  <= update_en && !sel_x_q;
      if (update_en) begin
        hp_q[cap_idx_q] <= cap_hp - HP_W'(1);
        score_q         <= score_next;
        if (kill) bricks_left_q <= bricks_left_q - 8'd1;
        hit_row_q       <= cap_r_q;
        hit_col_q       <= cap_c_q;
      end
      brick_on_q <= pix_row_hit && pix_col_hit && (hp_q[pix_idx] != '0);
      brick_hp_q <= (pix_row_hit && pix_col_hit) ? hp_q[pix_idx] : '0;
    end
  end

  assign bus.brick_on    = brick_on_q;
  assign bus.brick_hp    = brick_hp_q;
  assign bus.hit_valid   = hit_valid_q;
  assign bus.bounce_x    = bounce_x_q;
  assign bus.bounce_y    = bounce_y_q;
  assign bus.hit_row     = hit_row_q;
  assign bus.hit_col     = hit_col_q;
  assign bus.score       = score_q;
  assign bus.bricks_left = bricks_left_q;
  assign bus.field_clear = (bricks_left_q == 8'd0);
endmodule

// File: tb/tb_brick_field.sv
// Bench for brick_field: four parameterisations, frame results checked through a
// scoreboard of expected hit events.
module tb_brick_field;
  typedef struct packed {
    logic        hit;
    logic [7:0]  lat;
    logic        bx;
    logic        by;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [11:0] score;
    logic [7:0]  left;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [10:0] pix_x, pix_y, bxl, bxr, byt, byb;
  int          sel;
  int          n_cmp;
  int          n_bad;
  ev_t         sb[$];

  logic        m_hit, m_bx, m_by, m_on, m_clear;
  logic [3:0]  m_row, m_col;
  logic [1:0]  m_hp;
  logic [11:0] m_score;
  logic [7:0]  m_left;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  brick_field_if bus_a ();
  brick_field_if bus_b ();
  brick_field_if bus_c ();
  brick_field_if #(.SCORE_W(3)) bus_d ();

  assign bus_a.frame_tick = tick && (sel == 0);
  assign bus_b.frame_tick = tick && (sel == 1);
  assign bus_c.frame_tick = tick && (sel == 2);
  assign bus_d.frame_tick = tick && (sel == 3);
  assign bus_a.pix_x = pix_x;  assign bus_a.pix_y = pix_y;
  assign bus_b.pix_x = pix_x;  assign bus_b.pix_y = pix_y;
  assign bus_c.pix_x = pix_x;  assign bus_c.pix_y = pix_y;
  assign bus_d.pix_x = pix_x;  assign bus_d.pix_y = pix_y;
  assign bus_a.ball_x_l = bxl; assign bus_a.ball_x_r = bxr;
  assign bus_a.ball_y_t = byt; assign bus_a.ball_y_b = byb;
  assign bus_b.ball_x_l = bxl; assign bus_b.ball_x_r = bxr;
  assign bus_b.ball_y_t = byt; assign bus_b.ball_y_b = byb;
  assign bus_c.ball_x_l = bxl; assign bus_c.ball_x_r = bxr;
  assign bus_c.ball_y_t = byt; assign bus_c.ball_y_b = byb;
  assign bus_d.ball_x_l = bxl; assign bus_d.ball_x_r = bxr;
  assign bus_d.ball_y_t = byt; assign bus_d.ball_y_b = byb;

  brick_field u_dut (.clk(clk), .reset(reset), .bus(bus_a));
  brick_field #(.INIT_HP(2)) u_hp2 (.clk(clk), .reset(reset), .bus(bus_b));
  brick_field #(.NUM_ROWS(1), .NUM_COLS(1)) u_one (.clk(clk), .reset(reset), .bus(bus_c));
  brick_field #(.NUM_ROWS(1), .NUM_COLS(2), .INIT_HP(3), .SCORE_W(3), .PTS_KILL(6)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_d)
  );

  always_comb begin
    {m_hit, m_bx, m_by, m_on, m_clear} = {bus_a.hit_valid, bus_a.bounce_x, bus_a.bounce_y,
                                          bus_a.brick_on, bus_a.field_clear};
    {m_row, m_col, m_hp, m_score, m_left} = {bus_a.hit_row, bus_a.hit_col, bus_a.brick_hp,
                                             bus_a.score, bus_a.bricks_left};
    case (sel)
      1: begin
        {m_hit, m_bx, m_by, m_on, m_clear} = {bus_b.hit_valid, bus_b.bounce_x, bus_b.bounce_y,
                                              bus_b.brick_on, bus_b.field_clear};
        {m_row, m_col, m_hp, m_score, m_left} = {bus_b.hit_row, bus_b.hit_col, bus_b.brick_hp,
                                                 bus_b.score, bus_b.bricks_left};
      end
      2: begin
        {m_hit, m_bx, m_by, m_on, m_clear} = {bus_c.hit_valid, bus_c.bounce_x, bus_c.bounce_y,
                                              bus_c.brick_on, bus_c.field_clear};
        {m_row, m_col, m_hp, m_score, m_left} = {bus_c.hit_row, bus_c.hit_col, bus_c.brick_hp,
                                                 bus_c.score, bus_c.bricks_left};
      end
      3: begin
        {m_hit, m_bx, m_by, m_on, m_clear} = {bus_d.hit_valid, bus_d.bounce_x, bus_d.bounce_y,
                                              bus_d.brick_on, bus_d.field_clear};
        {m_row, m_col, m_hp, m_left} = {bus_d.hit_row, bus_d.hit_col, bus_d.brick_hp,
                                        bus_d.bricks_left};
        m_score = 12'(bus_d.score);
      end
      default: ;
    endcase
  end

  function automatic ev_t ev(bit hit, int lat, bit bx, bit by, int row, int col, int score,
                             int left);
    ev_t e;
    e = '{hit: hit, lat: 8'(lat), bx: bx, by: by, row: 4'(row), col: 4'(col),
          score: 12'(score), left: 8'(left)};
    return e;
  endfunction

  task automatic do_reset();
    tick  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_ball(input int xl, input int xr, input int yt, input int yb);
    bxl = 11'(xl); bxr = 11'(xr); byt = 11'(yt); byb = 11'(yb);
  endtask

  task automatic step_pix(input int x, input int y);
    pix_x = 11'(x); pix_y = 11'(y);
    @(posedge clk); #1;
  endtask

  // Pulses frame_tick and records the first hit within the window. At cycle `mid` either
  // reset is pulsed or a second tick is sent together with a different ball.
  task automatic run_frame(input int limit, input int mid, input bit mid_reset, output ev_t obs);
    obs = '0;
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (mid != 0 && k == mid + 1) begin reset = 1'b0; tick = 1'b0; end
      if (m_hit && !obs.hit) begin
        obs.hit = 1'b1; obs.lat = 8'(k); obs.bx = m_bx; obs.by = m_by;
        obs.row = m_row; obs.col = m_col;
      end
      if (mid != 0 && k == mid) begin
        if (mid_reset) reset = 1'b1;
        else begin tick = 1'b1; set_ball(0, 2, 0, 2); end
      end
    end
    obs.score = m_score;
    obs.left  = m_left;
  endtask

  task automatic test_reset();
    sel = 0;
    pix_x = 11'd9; pix_y = 11'd4;
    do_reset();
    n_cmp += 6;
    if (m_left !== 8'd40) begin n_bad++; $display("FAIL reset_left got %0d want 40", m_left); end
    if (m_score !== 12'd0) begin n_bad++; $display("FAIL reset_score got %0d want 0", m_score); end
    if (m_clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear got %b want 0", m_clear); end
    if ({m_hit, m_bx, m_by} !== 3'b000) begin
      n_bad++; $display("FAIL reset_pulses got %b want 000", {m_hit, m_bx, m_by});
    end
    if ({m_row, m_col} !== 8'h00) begin
      n_bad++; $display("FAIL reset_rowcol got %h want 00", {m_row, m_col});
    end
    if ({m_on, m_hp} !== 3'b000) begin
      n_bad++; $display("FAIL reset_pixel got %b want 000", {m_on, m_hp});
    end
  endtask

  task automatic test_pixel();
    sel = 0;
    do_reset();
    step_pix(115, 4);
    n_cmp++;
    if (m_on !== 1'b0) begin n_bad++; $display("FAIL pix_gap_x got %b want 0", m_on); end
    pix_x = 11'd9; pix_y = 11'd4; #1;
    n_cmp++;
    if (m_on !== 1'b0) begin n_bad++; $display("FAIL pix_latency got %b want 0", m_on); end
    @(posedge clk); #1;
    n_cmp++;
    if ({m_on, m_hp} !== 3'b101) begin
      n_bad++; $display("FAIL pix_corner got %b want 101", {m_on, m_hp});
    end
    step_pix(9, 20);
    n_cmp++;
    if (m_on !== 1'b0) begin n_bad++; $display("FAIL pix_gap_y got %b want 0", m_on); end
    step_pix(570, 180);
    n_cmp++;
    if (m_on !== 1'b1) begin n_bad++; $display("FAIL pix_last got %b want 1", m_on); end
    step_pix(571, 180);
    n_cmp++;
    if ({m_on, m_hp} !== 3'b000) begin
      n_bad++; $display("FAIL pix_past_last got %b want 000", {m_on, m_hp});
    end
  endtask

  task automatic test_bounce_x();
    ev_t obs, e;
    sel = 0;
    do_reset();
    set_ball(112, 119, 8, 15);
    sb.push_back(ev(1, 42, 1, 0, 0, 0, 5, 39));
    run_frame(50, 0, 0, obs);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL bounce_x got %h want %h", obs, e); end
  endtask

  task automatic test_bounce_y();
    ev_t obs, e;
    sel = 0;
    do_reset();
    set_ball(50, 57, 16, 23);
    sb.push_back(ev(1, 42, 0, 1, 0, 0, 5, 39));
    sb.push_back(ev(0, 0, 0, 0, 0, 0, 5, 39));
    for (int f = 0; f < 2; f++) begin
      run_frame(50, 0, 0, obs);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL bounce_y frame %0d got %h want %h", f, obs, e); end
    end
  endtask

  task automatic test_multi_hp();
    ev_t obs, e;
    sel = 1;
    do_reset();
    set_ball(112, 119, 8, 15);
    sb.push_back(ev(1, 42, 1, 0, 0, 0, 1, 40));
    sb.push_back(ev(1, 42, 1, 0, 0, 0, 6, 39));
    for (int f = 0; f < 2; f++) begin
      run_frame(50, 0, 0, obs);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL multi_hp frame %0d got %h want %h", f, obs, e); end
      if (f == 0) begin
        step_pix(20, 10);
        n_cmp++;
        if ({m_on, m_hp} !== 3'b101) begin
          n_bad++; $display("FAIL multi_hp_pixel got %b want 101", {m_on, m_hp});
        end
      end
    end
  endtask

  task automatic test_first_only();
    ev_t obs, e;
    int extra;
    sel = 0;
    do_reset();
    set_ball(100, 130, 8, 15);
    sb.push_back(ev(1, 42, 0, 1, 0, 0, 5, 39));
    run_frame(50, 5, 0, obs);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL first_only got %h want %h", obs, e); end
    extra = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (m_hit) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL tick_in_scan got %0d pulses want 0", extra); end
    step_pix(123, 4);
    n_cmp++;
    if (m_on !== 1'b1) begin n_bad++; $display("FAIL neighbour_live got %b want 1", m_on); end
    step_pix(9, 4);
    n_cmp++;
    if (m_on !== 1'b0) begin n_bad++; $display("FAIL hit_brick_dead got %b want 0", m_on); end
  endtask

  task automatic test_reset_abort();
    ev_t obs, e;
    sel = 0;
    do_reset();
    set_ball(112, 119, 8, 15);
    sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 40));
    run_frame(50, 10, 1, obs);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_abort got %h want %h", obs, e); end
  endtask

  task automatic test_field_clear();
    ev_t obs, e;
    sel = 2;
    do_reset();
    set_ball(112, 119, 8, 15);
    sb.push_back(ev(1, 3, 1, 0, 0, 0, 5, 0));
    sb.push_back(ev(0, 0, 0, 0, 0, 0, 5, 0));
    for (int f = 0; f < 2; f++) begin
      run_frame(10, 0, 0, obs);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL clear_frame %0d got %h want %h", f, obs, e); end
      n_cmp++;
      if (m_clear !== 1'b1) begin n_bad++; $display("FAIL field_clear got %b want 1", m_clear); end
    end
    do_reset();
    n_cmp++;
    if ({m_clear, m_left, m_score} !== {1'b0, 8'd1, 12'd0}) begin
      n_bad++;
      $display("FAIL clear_reset got clear=%b left=%0d score=%0d want 0/1/0", m_clear, m_left,
               m_score);
    end
  endtask

  task automatic test_saturate();
    ev_t obs, e;
    sel = 3;
    do_reset();
    set_ball(112, 125, 8, 15);
    sb.push_back(ev(1, 4, 1, 0, 0, 0, 1, 2));
    sb.push_back(ev(1, 4, 1, 0, 0, 0, 2, 2));
    sb.push_back(ev(1, 4, 1, 0, 0, 0, 7, 1));
    sb.push_back(ev(1, 4, 1, 0, 0, 1, 7, 1));
    for (int f = 0; f < 4; f++) begin
      run_frame(10, 0, 0, obs);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL saturate frame %0d got %h want %h", f, obs, e); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel   = 0;
    reset = 1'b1;
    tick  = 1'b0;
    pix_x = '0; pix_y = '0;
    set_ball(0, 0, 0, 0);
    test_reset();
    test_pixel();
    test_bounce_x();
    test_bounce_y();
    test_multi_hp();
    test_first_only();
    test_reset_abort();
    test_field_clear();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
